// File: rtl/get_reg.sv
// RISC-V register name translator: index -> ABI name (forward) and
// ASCII name -> index (reverse), each a one-cycle registered lookup.
module get_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        idx_valid,
    input  logic [5:0]  idx,
    input  logic        name_valid,
    input  logic [31:0] name_in,
    output logic [31:0] name_out,
    output logic        name_rdy,
    output logic        name_err,
    output logic [4:0]  idx_out,
    output logic        idx_rdy,
    output logic        idx_hit
);

    localparam logic [31:0] FP_NAME = 32'h0000_6670;

    function automatic logic [31:0] abi_name(input logic [4:0] i);
        logic [31:0] n;
        case (i)
            5'd0:  n = 32'h7A65_726F;
            5'd1:  n = 32'h0000_7261;
            5'd2:  n = 32'h0000_7370;
            5'd3:  n = 32'h0000_6770;
            5'd4:  n = 32'h0000_7470;
            5'd5:  n = 32'h0000_7430;
            5'd6:  n = 32'h0000_7431;
            5'd7:  n = 32'h0000_7432;
            5'd8:  n = 32'h0000_7330;
            5'd9:  n = 32'h0000_7331;
            5'd10: n = 32'h0000_6130;
            5'd11: n = 32'h0000_6131;
            5'd12: n = 32'h0000_6132;
            5'd13: n = 32'h0000_6133;
            5'd14: n = 32'h0000_6134;
            5'd15: n = 32'h0000_6135;
            5'd16: n = 32'h0000_6136;
            5'd17: n = 32'h0000_6137;
            5'd18: n = 32'h0000_7332;
            5'd19: n = 32'h0000_7333;
            5'd20: n = 32'h0000_7334;
            5'd21: n = 32'h0000_7335;
            5'd22: n = 32'h0000_7336;
            5'd23: n = 32'h0000_7337;
            5'd24: n = 32'h0000_7338;
            5'd25: n = 32'h0000_7339;
            5'd26: n = 32'h0073_3130;
            5'd27: n = 32'h0073_3131;
            5'd28: n = 32'h0000_7433;
            5'd29: n = 32'h0000_7434;
            5'd30: n = 32'h0000_7435;
            default: n = 32'h0000_7436;
        endcase
        return n;
    endfunction

    // Numeric alias "xN" with no leading zero, right-justified.
    function automatic logic [31:0] x_name(input int i);
        logic [31:0] n;
        if (i < 10)
            n = {16'h0000, 8'h78, 8'(32'h30 + i)};
        else
            n = {8'h00, 8'h78, 8'(32'h30 + i / 10), 8'(32'h30 + i % 10)};
        return n;
    endfunction

    logic [31:0] match;
    logic [4:0]  enc_idx;
    logic        any_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_rev
            localparam logic [31:0] ABI_N  = abi_name(5'(gi));
            localparam logic [31:0] X_N    = x_name(gi);
            localparam bit          FP_EN  = (gi == 8);
            assign match[gi] = (name_in == ABI_N) || (name_in == X_N) ||
                               (FP_EN && (name_in == FP_NAME));
        end
    endgenerate

    // At most one index can match a given string, so OR-ing indices is exact.
    always_comb begin
        enc_idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (match[i])
                enc_idx = enc_idx | 5'(i);
        end
        any_hit = |match;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            name_out <= 32'h0;
            name_err <= 1'b0;
            name_rdy <= 1'b0;
        end else begin
            name_rdy <= idx_valid;
            if (idx_valid) begin
                name_out <= idx[5] ? 32'h0 : abi_name(idx[4:0]);
                name_err <= idx[5];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_out <= 5'd0;
            idx_hit <= 1'b0;
            idx_rdy <= 1'b0;
        end else begin
            idx_rdy <= name_valid;
            if (name_valid) begin
                idx_out <= any_hit ? enc_idx : 5'd0;
                idx_hit <= any_hit;
            end
        end
    end

endmodule

// File: tb/tb_get_reg.sv
// Directed bench for get_reg: vector table, idx sweep, reset corner cases.
module tb_get_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        idx_valid;
    logic [5:0]  idx;
    logic        name_valid;
    logic [31:0] name_in;
    logic [31:0] name_out;
    logic        name_rdy;
    logic        name_err;
    logic [4:0]  idx_out;
    logic        idx_rdy;
    logic        idx_hit;

    int n_cmp = 0;
    int n_bad = 0;

    get_reg dut (
        .clk        (clk),
        .reset      (reset),
        .idx_valid  (idx_valid),
        .idx        (idx),
        .name_valid (name_valid),
        .name_in    (name_in),
        .name_out   (name_out),
        .name_rdy   (name_rdy),
        .name_err   (name_err),
        .idx_out    (idx_out),
        .idx_rdy    (idx_rdy),
        .idx_hit    (idx_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [5:0]  ix;
        logic        nv;
        logic [31:0] nm;
        logic [31:0] e_name;
        logic        e_err;
        logic        e_nrdy;
        logic [4:0]  e_idx;
        logic        e_hit;
        logic        e_irdy;
    } vec_t;

    vec_t vecs[20];
    logic [31:0] sweep_names[32];

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", what, act, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] en, input logic ee,
                             input logic er, input logic [4:0] ei, input logic eh,
                             input logic eir);
        chk({tag, ".name_out"}, name_out, en);
        chk({tag, ".name_err"}, 32'(name_err), 32'(ee));
        chk({tag, ".name_rdy"}, 32'(name_rdy), 32'(er));
        chk({tag, ".idx_out"},  32'(idx_out),  32'(ei));
        chk({tag, ".idx_hit"},  32'(idx_hit),  32'(eh));
        chk({tag, ".idx_rdy"},  32'(idx_rdy),  32'(eir));
    endtask

    task automatic drive(input logic iv, input logic [5:0] ix, input logic nv, input logic [31:0] nm);
        @(negedge clk);
        idx_valid  = iv;
        idx        = ix;
        name_valid = nv;
        name_in    = nm;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //        iv  idx   nv  name_in        e_name         err nrdy idx  hit irdy
        vecs[0]  = '{1, 6'd0,  0, 32'h0,         32'h7A65726F, 0, 1, 5'd0,  0, 0};
        vecs[1]  = '{1, 6'd31, 0, 32'h0,         32'h00007436, 0, 1, 5'd0,  0, 0};
        vecs[2]  = '{1, 6'd26, 0, 32'h0,         32'h00733130, 0, 1, 5'd0,  0, 0};
        vecs[3]  = '{1, 6'd40, 0, 32'h0,         32'h00000000, 1, 1, 5'd0,  0, 0};
        vecs[4]  = '{1, 6'd63, 0, 32'h0,         32'h00000000, 1, 1, 5'd0,  0, 0};
        vecs[5]  = '{0, 6'd3,  0, 32'h0,         32'h00000000, 1, 0, 5'd0,  0, 0};
        vecs[6]  = '{0, 6'd0,  1, 32'h00006670,  32'h00000000, 1, 0, 5'd8,  1, 1};
        vecs[7]  = '{0, 6'd0,  1, 32'h00006137,  32'h00000000, 1, 0, 5'd17, 1, 1};
        vecs[8]  = '{0, 6'd0,  1, 32'h00783331,  32'h00000000, 1, 0, 5'd31, 1, 1};
        vecs[9]  = '{0, 6'd0,  1, 32'h00733132,  32'h00000000, 1, 0, 5'd0,  0, 1};
        vecs[10] = '{0, 6'd0,  1, 32'h00783035,  32'h00000000, 1, 0, 5'd0,  0, 1};
        vecs[11] = '{0, 6'd0,  1, 32'h01007370,  32'h00000000, 1, 0, 5'd0,  0, 1};
        vecs[12] = '{0, 6'd0,  1, 32'h00783130,  32'h00000000, 1, 0, 5'd10, 1, 1};
        vecs[13] = '{0, 6'd0,  0, 32'h00006670,  32'h00000000, 1, 0, 5'd10, 1, 0};
        vecs[14] = '{1, 6'd2,  1, 32'h00007261,  32'h00007370, 0, 1, 5'd1,  1, 1};
        vecs[15] = '{0, 6'd9,  0, 32'h0,         32'h00007370, 0, 0, 5'd1,  1, 0};
        vecs[16] = '{1, 6'd8,  1, 32'h00007830,  32'h00007330, 0, 1, 5'd0,  1, 1};
        vecs[17] = '{1, 6'd17, 1, 32'h00007330,  32'h00006137, 0, 1, 5'd8,  1, 1};
        vecs[18] = '{1, 6'd32, 1, 32'h00007436,  32'h00000000, 1, 1, 5'd31, 1, 1};
        vecs[19] = '{0, 6'd5,  1, 32'h7A65726F,  32'h00000000, 1, 0, 5'd0,  1, 1};

        sweep_names = '{32'h7A65726F, 32'h00007261, 32'h00007370, 32'h00006770,
                        32'h00007470, 32'h00007430, 32'h00007431, 32'h00007432,
                        32'h00007330, 32'h00007331, 32'h00006130, 32'h00006131,
                        32'h00006132, 32'h00006133, 32'h00006134, 32'h00006135,
                        32'h00006136, 32'h00006137, 32'h00007332, 32'h00007333,
                        32'h00007334, 32'h00007335, 32'h00007336, 32'h00007337,
                        32'h00007338, 32'h00007339, 32'h00733130, 32'h00733131,
                        32'h00007433, 32'h00007434, 32'h00007435, 32'h00007436};

        // Reset with a request pending: request must be discarded.
        reset = 1'b1; idx_valid = 1'b1; idx = 6'd1; name_valid = 1'b1; name_in = 32'h00007261;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 32'h0, 0, 0, 5'd0, 0, 0);
        @(negedge clk);
        reset = 1'b0; idx_valid = 1'b0; name_valid = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_reset", 32'h0, 0, 0, 5'd0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].iv, vecs[i].ix, vecs[i].nv, vecs[i].nm);
            $display("vec %0d: idx_v=%0d idx=%0d name_v=%0d name_in=%08h -> name_out=%08h err=%0d rdy=%0d idx_out=%0d hit=%0d irdy=%0d",
                     i, vecs[i].iv, vecs[i].ix, vecs[i].nv, vecs[i].nm,
                     name_out, name_err, name_rdy, idx_out, idx_hit, idx_rdy);
            check_all($sformatf("vec%0d", i), vecs[i].e_name, vecs[i].e_err, vecs[i].e_nrdy,
                      vecs[i].e_idx, vecs[i].e_hit, vecs[i].e_irdy);
        end

        // Back-to-back sweep: one result per cycle.
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 6'(i), 1'b0, 32'h0);
            $display("sweep idx=%0d -> name_out=%08h rdy=%0d", i, name_out, name_rdy);
            chk($sformatf("sweep%0d.name_out", i), name_out, sweep_names[i]);
            chk($sformatf("sweep%0d.rdy", i), 32'(name_rdy), 32'd1);
            chk($sformatf("sweep%0d.err", i), 32'(name_err), 32'd0);
        end

        // Mid-stream asynchronous reset: outputs clear before any clock edge.
        drive(1'b1, 6'd4, 1'b1, 32'h00006137);
        check_all("pre_async", 32'h00007470, 0, 1, 5'd17, 1, 1);
        #2 reset = 1'b1;
        #1;
        $display("async reset -> name_out=%08h idx_out=%0d", name_out, idx_out);
        check_all("async_reset", 32'h0, 0, 0, 5'd0, 0, 0);
        @(negedge clk);
        reset = 1'b0; idx_valid = 1'b0; name_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("no_rdy_after_reset", 32'h0, 0, 0, 5'd0, 0, 0);

        // First request after reset appears exactly one cycle later.
        drive(1'b1, 6'd1, 1'b1, 32'h00007370);
        $display("first after reset -> name_out=%08h idx_out=%0d", name_out, idx_out);
        check_all("first_after_reset", 32'h00007261, 0, 1, 5'd2, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
